// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that feeds NUM_REQ byte streams into one
// uart_core TX FIFO over the slot bus, and keeps the core's baud divisor programmed.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter logic [10:0] DVSR_RESET = 11'd325
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  input  logic [10:0]            cfg_dvsr,
  input  logic                   cfg_wr,
  output logic                   cfg_pending,
  output logic                   uart_cs,
  output logic                   uart_write,
  output logic                   uart_read,
  output logic [4:0]             uart_addr,
  output logic [31:0]            uart_wr_data,
  input  logic [31:0]            uart_rd_data
);

  localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0]  ADDR_DVSR = 5'd1;
  localparam logic [4:0]  ADDR_TX   = 5'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CFG_WR,
    S_CHECK,
    S_PUSH
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [PTR_W-1:0]    r_owner;
  logic [PTR_W-1:0]    r_ptr;
  logic [10:0]         r_shadow;
  logic                r_pending;
  logic                r_last;
  logic                r_cs;
  logic                r_write;
  logic [4:0]          r_addr;
  logic [31:0]         r_wdata;

  logic                w_tx_full;
  logic [7:0]          w_owner_byte;
  logic                w_pick_found;
  logic [PTR_W-1:0]    w_pick_idx;
  logic                w_unused;

  // (base + off) mod NUM_REQ for base, off < NUM_REQ
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  assign w_tx_full    = uart_rd_data[9];
  assign w_unused     = ^{uart_rd_data[31:10], uart_rd_data[8:0]};
  assign w_owner_byte = req_data[32'(r_owner)*8 +: 8];

  // First valid requester at or above the RR pointer, wrapping around
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_pick_found && req_valid[wrap_add(r_ptr, k)]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = wrap_add(r_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_shadow  <= DVSR_RESET;
      r_pending <= 1'b1;
      r_last    <= 1'b0;
      r_cs      <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_cs    <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;

      if (cfg_wr) begin
        r_shadow  <= cfg_dvsr;
        r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_cs    <= 1'b1;
            r_write <= 1'b1;
            r_addr  <= ADDR_DVSR;
            r_wdata <= {21'd0, r_shadow};
            r_state <= S_CFG_WR;
          end else if (w_pick_found) begin
            r_grant <= NUM_REQ'(1) << w_pick_idx;
            r_owner <= w_pick_idx;
            r_state <= S_CHECK;
          end
        end

        // A strobe arriving alongside the divisor write re-arms the pending flag
        S_CFG_WR: begin
          if (!cfg_wr) r_pending <= 1'b0;
          r_state <= S_IDLE;
        end

        S_CHECK: begin
          if (req_valid[r_owner] && !w_tx_full) begin
            r_last  <= req_last[r_owner];
            r_cs    <= 1'b1;
            r_write <= 1'b1;
            r_addr  <= ADDR_TX;
            r_wdata <= {24'd0, w_owner_byte};
            r_state <= S_PUSH;
          end
        end

        S_PUSH: begin
          if (r_last) begin
            r_grant <= '0;
            r_ptr   <= wrap_add(r_owner, 32'd1);
            r_state <= S_IDLE;
          end else begin
            r_state <= S_CHECK;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ready tracks tx_full in the same cycle so an accept never overruns the FIFO
  assign req_ready    = (r_state == S_CHECK && !w_tx_full) ? r_grant : '0;
  assign grant        = r_grant;
  assign busy         = (r_state != S_IDLE);
  assign cfg_pending  = r_pending;
  assign uart_cs      = r_cs;
  assign uart_write   = r_write;
  assign uart_read    = 1'b0;
  assign uart_addr    = r_addr;
  assign uart_wr_data = r_wdata;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a cycle vector table for the basic protocol, then
// queue-driven requester sequences for arbitration order, config deferral and reset.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        busy;
  logic [10:0] cfg_dvsr;
  logic        cfg_wr;
  logic        cfg_pending;
  logic        uart_cs;
  logic        uart_write;
  logic        uart_read;
  logic [4:0]  uart_addr;
  logic [31:0] uart_wr_data;
  logic [31:0] uart_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DVSR_RESET(11'd325)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy),
    .cfg_dvsr(cfg_dvsr), .cfg_wr(cfg_wr), .cfg_pending(cfg_pending),
    .uart_cs(uart_cs), .uart_write(uart_write), .uart_read(uart_read),
    .uart_addr(uart_addr), .uart_wr_data(uart_wr_data), .uart_rd_data(uart_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          reps;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        tx_full;
    logic [3:0]  e_ready;
    logic        e_cs;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic        e_pend;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  // Per-requester byte sources {last, byte} and expected slot writes {addr, data}
  logic [8:0]  src_mem[4][16];
  int          src_rd[4];
  int          src_wr[4];
  logic [36:0] exp_q[$];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_src(input int i, input logic [7:0] b, input logic l);
    src_mem[i][src_wr[i]] = {l, b};
    src_wr[i]++;
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // One cycle of the requester model; starts and ends at a falling edge
  task automatic step(input logic cw, input logic [10:0] dv);
    logic [3:0]  hs;
    logic [36:0] e;
    for (int i = 0; i < 4; i++) begin
      if (src_rd[i] != src_wr[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_rd[i]][7:0];
        req_last[i]        = src_mem[i][src_rd[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    cfg_wr       = cw;
    cfg_dvsr     = dv;
    uart_rd_data = '0;
    #1;
    hs = req_valid & req_ready;
    chk("ready_outside_grant", 40'(req_ready & ~grant), 40'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) src_rd[i]++;
    if (uart_cs && uart_write) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                 uart_addr, uart_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("slot_write", 40'({uart_addr, uart_wr_data}), 40'(e));
      end
    end else begin
      chk("slot_quiet", 40'({uart_cs, uart_write, uart_read, uart_addr, uart_wr_data}), 40'd0);
    end
    cfg_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1'b0, 11'd0);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL write_timeout: got %0d writes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drain(input int budget);
    int left;
    run_until_empty(budget);
    step(1'b0, 11'd0);
    left = 0;
    for (int i = 0; i < 4; i++) left += src_wr[i] - src_rd[i];
    chk("src_consumed", 40'(left), 40'd0);
    chk("idle_grant", 40'(grant), 40'd0);
    chk("idle_busy", 40'(busy), 40'd0);
    chk("idle_pending", 40'(cfg_pending), 40'd0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_grant", 40'(grant), 40'd0);
    chk("rst_ready", 40'(req_ready), 40'd0);
    chk("rst_slot", 40'({uart_cs, uart_write, uart_read, uart_addr, uart_wr_data}), 40'd0);
    chk("rst_busy_pend", 40'({busy, cfg_pending}), 40'b01);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    cfg_wr       = 1'b0;
    cfg_dvsr     = '0;
    uart_rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end

    //             reps valid  data          last  txf   e_ready e_cs  e_addr e_wdata     e_grant e_busy e_pend
    vecs[0]  = '{1,  4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b1, 5'd1, 32'd325,    4'h0, 1'b1, 1'b1};
    vecs[1]  = '{1,  4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h0, 1'b0, 1'b0};
    vecs[2]  = '{1,  4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h0, 1'b0, 1'b0};
    vecs[3]  = '{1,  4'h1, 32'h0000_00A5, 4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h1, 1'b1, 1'b0};
    vecs[4]  = '{1,  4'h1, 32'h0000_00A5, 4'h0, 1'b0, 4'h1, 1'b1, 5'd2, 32'hA5,     4'h1, 1'b1, 1'b0};
    vecs[5]  = '{1,  4'h1, 32'h0000_005A, 4'h1, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h1, 1'b1, 1'b0};
    vecs[6]  = '{1,  4'h1, 32'h0000_005A, 4'h1, 1'b0, 4'h1, 1'b1, 5'd2, 32'h5A,     4'h1, 1'b1, 1'b0};
    vecs[7]  = '{1,  4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h0, 1'b0, 1'b0};
    vecs[8]  = '{1,  4'h2, 32'h0000_1100, 4'h2, 1'b1, 4'h0, 1'b0, 5'd0, 32'h0,      4'h2, 1'b1, 1'b0};
    vecs[9]  = '{10, 4'h2, 32'h0000_1100, 4'h2, 1'b1, 4'h0, 1'b0, 5'd0, 32'h0,      4'h2, 1'b1, 1'b0};
    vecs[10] = '{1,  4'h2, 32'h0000_1100, 4'h2, 1'b0, 4'h2, 1'b1, 5'd2, 32'h11,     4'h2, 1'b1, 1'b0};
    vecs[11] = '{1,  4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h0, 1'b0, 1'b0};
    vecs[12] = '{1,  4'h3, 32'h0000_2233, 4'h3, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h1, 1'b1, 1'b0};
    vecs[13] = '{1,  4'h3, 32'h0000_2233, 4'h3, 1'b0, 4'h1, 1'b1, 5'd2, 32'h33,     4'h1, 1'b1, 1'b0};
    vecs[14] = '{1,  4'h2, 32'h0000_2233, 4'h3, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h0, 1'b0, 1'b0};
    vecs[15] = '{1,  4'h2, 32'h0000_2233, 4'h3, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h2, 1'b1, 1'b0};
    vecs[16] = '{1,  4'h2, 32'h0000_2233, 4'h3, 1'b0, 4'h2, 1'b1, 5'd2, 32'h22,     4'h2, 1'b1, 1'b0};
    vecs[17] = '{1,  4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0,      4'h0, 1'b0, 1'b0};

    @(negedge clk);
    @(negedge clk);
    chk("reset_slot", 40'({uart_cs, uart_write, uart_read, uart_addr, uart_wr_data}), 40'd0);
    chk("reset_grant_ready", 40'({grant, req_ready}), 40'd0);
    chk("reset_busy_pend", 40'({busy, cfg_pending}), 40'b01);
    reset_n = 1'b1;

    // Cycle table: startup divisor write, 2-byte packet, tx_full stall, RR wrap
    for (int v = 0; v < NV; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        req_valid    = vecs[v].valid;
        req_data     = vecs[v].data;
        req_last     = vecs[v].last;
        uart_rd_data = {22'd0, vecs[v].tx_full, 9'd0};
        #1;
        chk($sformatf("v%0d_ready", v), 40'(req_ready), 40'(vecs[v].e_ready));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_strobes", v), 40'({uart_cs, uart_write}),
            40'({vecs[v].e_cs, vecs[v].e_cs}));
        chk($sformatf("v%0d_addr", v), 40'(uart_addr), 40'(vecs[v].e_addr));
        chk($sformatf("v%0d_wdata", v), 40'(uart_wr_data), 40'(vecs[v].e_wdata));
        chk($sformatf("v%0d_grant", v), 40'(grant), 40'(vecs[v].e_grant));
        chk($sformatf("v%0d_busy", v), 40'(busy), 40'(vecs[v].e_busy));
        chk($sformatf("v%0d_pend", v), 40'(cfg_pending), 40'(vecs[v].e_pend));
        @(negedge clk);
      end
    end

    // Fresh reset so the RR pointer starts at 0
    pulse_reset();
    exp_wr(5'd1, 32'd325);
    drain(10);

    // Requesters 1 and 2 contend: 1's whole packet, then 2's; pointer ends at 3
    add_src(1, 8'h10, 1'b0); add_src(1, 8'h11, 1'b1);
    add_src(2, 8'h20, 1'b0); add_src(2, 8'h21, 1'b1);
    exp_wr(5'd2, 32'h10); exp_wr(5'd2, 32'h11);
    exp_wr(5'd2, 32'h20); exp_wr(5'd2, 32'h21);
    drain(40);
    add_src(0, 8'h00, 1'b1);
    add_src(3, 8'h30, 1'b1);
    exp_wr(5'd2, 32'h30); exp_wr(5'd2, 32'h00);
    drain(40);

    // Divisor update mid-packet waits for the packet, then precedes the next grant
    add_src(1, 8'h40, 1'b0); add_src(1, 8'h41, 1'b0); add_src(1, 8'h42, 1'b1);
    add_src(2, 8'h50, 1'b1);
    exp_wr(5'd2, 32'h40); exp_wr(5'd2, 32'h41); exp_wr(5'd2, 32'h42);
    exp_wr(5'd1, 32'd54); exp_wr(5'd2, 32'h50);
    step(1'b0, 11'd0);
    step(1'b0, 11'd0);
    step(1'b1, 11'd54);
    chk("cfg_deferred_pending", 40'(cfg_pending), 40'd1);
    drain(60);

    // Two updates inside one packet: only the last value is written
    add_src(3, 8'h60, 1'b0); add_src(3, 8'h61, 1'b1);
    exp_wr(5'd2, 32'h60); exp_wr(5'd2, 32'h61); exp_wr(5'd1, 32'd27);
    step(1'b1, 11'd54);
    step(1'b1, 11'd27);
    drain(40);

    // Move the pointer to 1, then reset partway through requester 1's packet
    add_src(0, 8'h80, 1'b1);
    exp_wr(5'd2, 32'h80);
    drain(20);
    add_src(1, 8'h70, 1'b0); add_src(1, 8'h71, 1'b0); add_src(1, 8'h72, 1'b1);
    add_src(0, 8'h90, 1'b1);
    exp_wr(5'd2, 32'h70);
    run_until_empty(20);
    pulse_reset();
    exp_wr(5'd1, 32'd325);
    exp_wr(5'd2, 32'h90);
    exp_wr(5'd2, 32'h71); exp_wr(5'd2, 32'h72);
    drain(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
